// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, VEC layout, source limit.
// Used by intr_ctrl, intc_prio_enc and the bus interface users.
package intr_ctrl_pkg;

    localparam int MAX_SRC       = 16;
    localparam int VEC_VALID_BIT = 31;
    localparam int IDX_W         = $clog2(MAX_SRC);

    typedef enum logic [1:0] {
        INTC_PEND = 2'd0,
        INTC_MASK = 2'd1,
        INTC_MODE = 2'd2,
        INTC_VEC  = 2'd3
    } intc_reg_e;

    // VEC word: valid flag in the top bit, winning index in the low nibble (0 when nothing pends).
    function automatic logic [31:0] vec_word(input logic valid, input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w                = 32'd0;
        w[VEC_VALID_BIT] = valid;
        w[IDX_W-1:0]     = valid ? idx : {IDX_W{1'b0}};
        return w;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bridge-side register bus of the interrupt controller (same Addr/WE/Din/Dout shape as the timers).
interface intr_ctrl_if;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder for the masked pending vector (index 0 = highest priority).
module intc_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            valid = valid | req[i];
            idx   = req[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source edge/level latching, mask, registered HWInt/IRQ, bridge registers.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on every src bit ahead of edge/level sampling.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    intr_ctrl_if.slave       bus,
    input  logic [N_SRC-1:0] src,
    output logic [N_SRC-1:0] HWInt,
    output logic             IRQ
);

    localparam int PAD_W = 32 - N_SRC;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_q, pend_q, mask_q, mode_q, hw_q;
    logic [N_SRC-1:0] pend_d, mask_d, mode_d, hw_d;
    logic             irq_q, irq_d;
    logic [N_SRC-1:0] w1c_s, to_edge_s, edge_set_s;
    logic [N_SRC-1:0] din_s;
    intc_reg_e        reg_sel_s;
    logic             vec_valid_s;
    logic [IDX_W-1:0] vec_idx_s;
    logic [31:0]      dout_s;
    logic             unused_s;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-stage synchronizer for asynchronous device IRQ lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= {N_SRC{1'b0}};
            sync2_q <= {N_SRC{1'b0}};
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    assign reg_sel_s = intc_reg_e'(bus.Addr[3:2]);
    assign din_s     = bus.Din[N_SRC-1:0];
    assign unused_s  = ^{bus.Addr[31:4], bus.Din};

    // Decode register writes into W1C strobes and new MASK/MODE values.
    always_comb begin
        w1c_s  = {N_SRC{1'b0}};
        mask_d = mask_q;
        mode_d = mode_q;
        if (bus.WE) begin
            case (reg_sel_s)
                INTC_PEND: w1c_s  = din_s;
                INTC_MASK: mask_d = din_s;
                INTC_MODE: mode_d = din_s;
                default:   w1c_s  = {N_SRC{1'b0}};
            endcase
        end else begin
            w1c_s = {N_SRC{1'b0}};
        end
    end

    // Pending update: an edge beats a same-cycle W1C; switching a bit to edge mode restarts it at 0.
    always_comb begin
        edge_set_s = src_s & ~src_q;
        to_edge_s  = mode_d & ~mode_q;
        pend_d     = ~to_edge_s & ((mode_q & (edge_set_s | (pend_q & ~w1c_s))) | (~mode_q & src_s));
        hw_d       = pend_q & mask_q;
        irq_d      = |hw_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q  <= {N_SRC{1'b0}};
            pend_q <= {N_SRC{1'b0}};
            mask_q <= {N_SRC{1'b0}};
            mode_q <= {N_SRC{1'b0}};
            hw_q   <= {N_SRC{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            src_q  <= src_s;
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            hw_q   <= hw_d;
            irq_q  <= irq_d;
        end
    end

    intc_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req   (pend_q & mask_q),
        .valid (vec_valid_s),
        .idx   (vec_idx_s)
    );

    // Read mux; VEC is live from the current PEND&MASK.
    always_comb begin
        dout_s = 32'd0;
        case (reg_sel_s)
            INTC_PEND: dout_s = {{PAD_W{1'b0}}, pend_q};
            INTC_MASK: dout_s = {{PAD_W{1'b0}}, mask_q};
            INTC_MODE: dout_s = {{PAD_W{1'b0}}, mode_q};
            INTC_VEC:  dout_s = vec_word(vec_valid_s, vec_idx_s);
            default:   dout_s = 32'd0;
        endcase
    end

    assign bus.Dout = dout_s;
    assign HWInt    = hw_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a rule-level model predicts Dout/HWInt/IRQ every cycle,
// directed scenarios followed by randomized register/src traffic.
module tb_intr_ctrl;
    import intr_ctrl_pkg::*;

    localparam int N = 6;
`ifdef INTC_SYNC_EN
    localparam int SDLY = 2;
`else
    localparam int SDLY = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;
    logic [N-1:0] HWInt;
    logic         IRQ;

    intr_ctrl_if bus ();

    intr_ctrl #(.N_SRC(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .src   (src),
        .HWInt (HWInt),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [N-1:0] hw;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   hold_rst = 1'b0;

    // Reference model state: what the registers hold right now.
    bit [N-1:0] m_pend, m_mask, m_mode, m_prev, m_hw;
    bit         m_irq;
    bit [N-1:0] m_hist[$];

    function automatic void m_reset();
        m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0; m_hw = '0; m_irq = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SDLY; i++) m_hist.push_back('0);
    endfunction

    function automatic logic [31:0] m_read(input bit [1:0] a);
        bit [N-1:0] pm;
        logic [31:0] v;
        pm = m_pend & m_mask;
        v  = 32'd0;
        case (a)
            2'd0: v = 32'(m_pend);
            2'd1: v = 32'(m_mask);
            2'd2: v = 32'(m_mode);
            default: begin
                for (int i = N - 1; i >= 0; i--)
                    if (pm[i]) v = 32'h8000_0000 | 32'(i);
            end
        endcase
        return v;
    endfunction

    function automatic void m_clock(input bit [1:0] a, input bit we, input bit [31:0] din,
                                    input bit [N-1:0] s);
        bit [N-1:0] seen, np, nmask, nmode;
        m_hist.push_back(s);
        seen  = m_hist.pop_front();
        nmask = (we && a == 2'd1) ? din[N-1:0] : m_mask;
        nmode = (we && a == 2'd2) ? din[N-1:0] : m_mode;
        for (int i = 0; i < N; i++) begin
            if (nmode[i] && !m_mode[i])             np[i] = 1'b0;
            else if (!m_mode[i])                    np[i] = seen[i];
            else if (seen[i] && !m_prev[i])         np[i] = 1'b1;
            else if (we && a == 2'd0 && din[i])     np[i] = 1'b0;
            else                                    np[i] = m_pend[i];
        end
        m_hw   = m_pend & m_mask;
        m_irq  = (m_hw != '0);
        m_pend = np;
        m_mask = nmask;
        m_mode = nmode;
        m_prev = seen;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endfunction

    // One bus cycle: drive, predict what the monitor will see this cycle, then advance the model.
    task automatic step(input bit [1:0] a, input bit we, input bit [31:0] din,
                        input bit [N-1:0] s, input string tag);
        exp_t e;
        bus.Addr = {28'd0, a};
        bus.WE   = we;
        bus.Din  = din;
        src      = s;
        e.dout = m_read(a);
        e.hw   = m_hw;
        e.irq  = m_irq;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        if (!hold_rst) m_clock(a, we, din, s);
        #1;
    endtask

    // Monitor: one snapshot per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".dout"},  bus.Dout,    e.dout);
            chk({e.tag, ".hwint"}, 32'(HWInt),  32'(e.hw));
            chk({e.tag, ".irq"},   32'(IRQ),    32'(e.irq));
        end
    end

    bit [N-1:0] rs;

    initial begin
        reset    = 1'b0;
        hold_rst = 1'b1;
        src      = 6'h3F;
        bus.Addr = 30'd0;
        bus.WE   = 1'b0;
        bus.Din  = 32'd0;
        m_reset();
        @(posedge clk); #1;

        // Reset held with all sources high: every register reads 0.
        for (int k = 0; k < 4; k++) step(2'(k), 1'b0, 32'd0, 6'h3F, "rst_hold");
        reset = 1'b1; hold_rst = 1'b0;
        for (int k = 0; k < 4; k++) step(2'(k), 1'b0, 32'd0, 6'h00, "rst_rel");

        // Edge latch, hold after src drops, W1C clears.
        step(INTC_MODE, 1'b1, 32'h1, 6'h00, "edge_cfg");
        step(INTC_MASK, 1'b1, 32'h1, 6'h00, "edge_cfg");
        step(INTC_PEND, 1'b0, 32'h0, 6'h01, "edge_pulse");
        for (int k = 0; k < 5; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h00, "edge_hold");
        step(INTC_PEND, 1'b1, 32'h1, 6'h00, "edge_w1c");
        for (int k = 0; k < 3; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h00, "edge_clr");

        // Level mode follows src; W1C has no effect.
        step(INTC_MODE, 1'b1, 32'h0, 6'h00, "lvl_cfg");
        step(INTC_MASK, 1'b1, 32'h4, 6'h00, "lvl_cfg");
        for (int k = 0; k < 3; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h04, "lvl_hi");
        for (int k = 0; k < 3; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h00, "lvl_lo");
        step(INTC_PEND, 1'b0, 32'h0, 6'h04, "lvl_hi2");
        step(INTC_PEND, 1'b1, 32'h4, 6'h04, "lvl_w1c");
        for (int k = 0; k < 3; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h04, "lvl_w1c_after");

        // Mask and priority on VEC.
        step(INTC_MODE, 1'b1, 32'h3F, 6'h00, "prio_cfg");
        for (int k = 0; k < 2; k++) step(INTC_VEC, 1'b0, 32'h0, 6'h00, "prio_idle");
        step(INTC_MASK, 1'b1, 32'h20, 6'h28, "prio_edges");
        for (int k = 0; k < 3; k++) step(INTC_VEC, 1'b0, 32'h0, 6'h00, "prio_m20");
        step(INTC_MASK, 1'b1, 32'h28, 6'h00, "prio_set");
        for (int k = 0; k < 3; k++) step(INTC_VEC, 1'b0, 32'h0, 6'h00, "prio_m28");
        step(INTC_VEC, 1'b1, 32'hFFFF_FFFF, 6'h00, "vec_wr");
        step(INTC_MASK, 1'b1, 32'h00, 6'h00, "prio_set0");
        for (int k = 0; k < 3; k++) step(INTC_VEC, 1'b0, 32'h0, 6'h00, "prio_m0");
        step(INTC_PEND, 1'b0, 32'h0, 6'h00, "prio_pend");
        step(INTC_MASK, 1'b0, 32'h3F, 6'h00, "we0_ignored");
        step(INTC_MASK, 1'b0, 32'h0, 6'h00, "we0_ignored");

        // Edge arriving in the same cycle as W1C of that bit: set wins.
        step(INTC_PEND, 1'b1, 32'h3F, 6'h00, "col_clr");
        step(INTC_MASK, 1'b1, 32'h2, 6'h02, "col_pre");
        step(INTC_PEND, 1'b0, 32'h0, 6'h00, "col_pre");
        for (int k = 0; k < SDLY; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h00, "col_wait");
        step(INTC_PEND, 1'b1, 32'h2, 6'h02, "col_hit");
        for (int k = 0; k < 4; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h02, "col_after");

        // Mid-operation reset drops state immediately.
        step(INTC_MASK, 1'b1, 32'h11, 6'h00, "mid_cfg");
        step(INTC_PEND, 1'b1, 32'h3F, 6'h11, "mid_edges");
        for (int k = 0; k < 3 + SDLY; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h11, "mid_pend");
        reset = 1'b0; hold_rst = 1'b1; m_reset();
        step(INTC_PEND, 1'b0, 32'h0, 6'h11, "mid_rst");
        step(INTC_MASK, 1'b0, 32'h0, 6'h11, "mid_rst");
        reset = 1'b1; hold_rst = 1'b0;
        for (int k = 0; k < 3; k++) step(INTC_PEND, 1'b0, 32'h0, 6'h00, "mid_rel");

        // Randomized register traffic with toggling sources.
        rs = '0;
        for (int k = 0; k < 600; k++) begin
            rs = rs ^ N'($urandom & $urandom & $urandom);
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 63)),
                 rs, "rand");
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
